// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-dump engine.
// The optional checksum word is enabled with REG_DUMP_CSUM_EN.
package reg_dump_pkg;

    localparam int IDX_W    = 6;
    localparam int ADR_W    = 5;
    localparam int CSUM_IDX = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        SEND = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/reg_dump_if.sv
// Control, register-file read port and output stream of the dump engine.
// master = dump engine side, slave = requester / register file / consumer side.
interface reg_dump_if #(parameter int DW = 32) ();
    import reg_dump_pkg::*;

    logic             Start;
    logic             Abort;
    logic [ADR_W-1:0] RdAdr;
    logic [DW-1:0]    RdData;
    logic [DW-1:0]    OutData;
    logic [IDX_W-1:0] OutIdx;
    logic             OutValid;
    logic             OutReady;
    logic             Busy;
    logic             Done;

    modport master (
        input  Start, Abort, RdData, OutReady,
        output RdAdr, OutData, OutIdx, OutValid, Busy, Done
    );

    modport slave (
        output Start, Abort, RdData, OutReady,
        input  RdAdr, OutData, OutIdx, OutValid, Busy, Done
    );

endinterface

// File: rtl/reg_dump_csum.sv
// XOR accumulator over the words streamed by reg_dump (built only with REG_DUMP_CSUM_EN).
// Exposes the next value so the checksum word can be loaded on the same edge as the last data transfer.
module reg_dump_csum
    import reg_dump_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_s,
    input  logic          en_s,
    input  logic [DW-1:0] din_s,
    output logic [DW-1:0] csum_nxt_s
);

    logic [DW-1:0] csum_r;

    // Next accumulator value: clear has priority over accumulation.
    always_comb begin
        csum_nxt_s = csum_r;
        if (clr_s) begin
            csum_nxt_s = {DW{1'b0}};
        end else if (en_s) begin
            csum_nxt_s = csum_r ^ din_s;
        end else begin
            csum_nxt_s = csum_r;
        end
    end

    // Accumulator register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_r <= {DW{1'b0}};
        end else begin
            csum_r <= csum_nxt_s;
        end
    end

endmodule

// File: rtl/reg_dump.sv
// Streams registers 0..NREG-1 out of a combinational register-file read port, one word per two cycles.
// Define REG_DUMP_CSUM_EN to append an XOR checksum word tagged with index NREG.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic CLK,
    input  logic RST_N,
    reg_dump_if.master bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREG - 1);

    state_e           state_r;
    state_e           state_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_s;
    logic             xfer_s;
    logic             abort_s;

    logic [ADR_W-1:0] rd_adr_r;
    logic [DW-1:0]    out_data_r;
    logic [IDX_W-1:0] out_idx_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             done_r;

    assign xfer_s  = out_valid_r && bus.OutReady;
    assign abort_s = bus.Abort && (state_r != IDLE);

    // State and index registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= IDLE;
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
        end
    end

    // Next-state logic; abort overrides any transfer in the same cycle.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        if (abort_s) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.Start) begin
                        state_s = READ;
                        idx_s   = {IDX_W{1'b0}};
                    end else begin
                        state_s = IDLE;
                    end
                end
                READ: state_s = SEND;
                SEND: begin
                    if (!xfer_s) begin
                        state_s = SEND;
                    end else if (idx_r == LAST_IDX) begin
`ifdef REG_DUMP_CSUM_EN
                        state_s = CSUM;
`else
                        state_s = DONE;
`endif
                    end else begin
                        idx_s   = idx_r + 6'd1;
                        state_s = READ;
                    end
                end
                CSUM: begin
`ifdef REG_DUMP_CSUM_EN
                    if (xfer_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = CSUM;
                    end
`else
                    state_s = IDLE;
`endif
                end
                DONE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

`ifdef REG_DUMP_CSUM_EN
    logic [DW-1:0] csum_nxt_s;

    reg_dump_csum #(.DW(DW)) u_csum (
        .clk       (CLK),
        .rst_n     (RST_N),
        .clr_s     ((state_r == IDLE) && bus.Start),
        .en_s      ((state_r == SEND) && xfer_s && !bus.Abort),
        .din_s     (out_data_r),
        .csum_nxt_s(csum_nxt_s)
    );
`endif

    // Outputs are registered from the next state so RdAdr is already valid during READ.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rd_adr_r    <= {ADR_W{1'b0}};
            out_data_r  <= {DW{1'b0}};
            out_idx_r   <= {IDX_W{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            rd_adr_r <= (state_s == READ) ? idx_s[ADR_W-1:0] : {ADR_W{1'b0}};
            busy_r   <= (state_s != IDLE);
            done_r   <= (state_s == DONE);
            if ((state_r == READ) && (state_s == SEND)) begin
                out_data_r  <= bus.RdData;
                out_idx_r   <= idx_r;
                out_valid_r <= 1'b1;
`ifdef REG_DUMP_CSUM_EN
            end else if ((state_r == SEND) && (state_s == CSUM)) begin
                out_data_r  <= csum_nxt_s;
                out_idx_r   <= IDX_W'(NREG);
                out_valid_r <= 1'b1;
`endif
            end else if ((state_s == SEND) || (state_s == CSUM)) begin
                // Stalled by the consumer: word and tag stay put whatever RdData does.
                out_valid_r <= out_valid_r;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.RdAdr    = rd_adr_r;
    assign bus.OutData  = out_data_r;
    assign bus.OutIdx   = out_idx_r;
    assign bus.OutValid = out_valid_r;
    assign bus.Busy     = busy_r;
    assign bus.Done     = done_r;

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: a dump request pushes every expected word; a monitor pops on each transfer.
// Build with REG_DUMP_CSUM_EN to also expect the trailing checksum word.
module tb_reg_dump;
    import reg_dump_pkg::*;

    localparam int NREG = 32;
    localparam int DW   = 32;
`ifdef REG_DUMP_CSUM_EN
    localparam int NWORDS  = NREG + 1;
    localparam int EXP_CYC = 2 * NREG + 2;
`else
    localparam int NWORDS  = NREG;
    localparam int EXP_CYC = 2 * NREG + 1;
`endif

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [DW-1:0]    data;
        logic             last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_dump_if #(.DW(DW)) bus ();

    reg_dump #(.NREG(NREG), .DW(DW)) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus)
    );

    logic [DW-1:0] regs [NREG];
    logic          junk_en;
    logic [DW-1:0] junk;
    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            xfers  = 0;
    logic          done_due;
    bit            rand_rdy;

    // Register file read port; junk_en models unrelated RdData activity while stalled.
    always_comb bus.RdData = junk_en ? junk : regs[bus.RdAdr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.OutReady = 1'($urandom_range(0, 1));
    endtask

    // Reference model: a dump is every register in index order, plus their XOR when enabled.
    task automatic issue_start();
        exp_t          e;
        logic [DW-1:0] acc;
        acc = {DW{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            e.idx  = IDX_W'(i);
            e.data = regs[i];
            e.last = (NWORDS == NREG) && (i == NREG - 1);
            exp_q.push_back(e);
            acc = acc ^ regs[i];
        end
        if (NWORDS > NREG) begin
            e.idx  = IDX_W'(CSUM_IDX);
            e.data = acc;
            e.last = 1'b1;
            exp_q.push_back(e);
        end
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic wait_done(inout int cyc);
        while (!bus.Done && cyc < 2000) begin
            tick();
            cyc++;
        end
        chk("done_reached", 64'(bus.Done), 64'd1);
    endtask

    task automatic wait_idx(input int k);
        int n = 0;
        while (!(bus.OutValid && bus.OutIdx == IDX_W'(k)) && n < 300) begin
            tick();
            n++;
        end
        chk("reach_idx", 64'(bus.OutIdx), 64'(k));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_OutData"},  64'(bus.OutData),  64'd0);
        chk({tag, "_OutIdx"},   64'(bus.OutIdx),   64'd0);
        chk({tag, "_OutValid"}, 64'(bus.OutValid), 64'd0);
        chk({tag, "_Busy"},     64'(bus.Busy),     64'd0);
        chk({tag, "_Done"},     64'(bus.Done),     64'd0);
        chk({tag, "_RdAdr"},    64'(bus.RdAdr),    64'd0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_due = 1'b0;
            end else begin
                if (bus.Done || done_due) chk("done_pulse", 64'(bus.Done), 64'(done_due));
                done_due = 1'b0;
                if (bus.OutValid && bus.OutReady && !bus.Abort) begin
                    xfers++;
                    chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("sb_idx",  64'(bus.OutIdx),  64'(e.idx));
                        chk("sb_data", 64'(bus.OutData), 64'(e.data));
                        done_due = e.last;
                    end
                end
            end
        end
    endtask

    task automatic load_pattern();
        for (int i = 0; i < NREG; i++) regs[i] = 32'(i) * 32'h11111111;
    endtask

    initial begin
        int cyc;
        int x0;
        rst_n = 1'b0;
        bus.Start = 1'b0;
        bus.Abort = 1'b0;
        bus.OutReady = 1'b0;
        junk_en = 1'b0;
        junk = {DW{1'b0}};
        rand_rdy = 1'b0;
        done_due = 1'b0;
        for (int i = 0; i < NREG; i++) regs[i] = {DW{1'b0}};
        fork
            monitor();
        join_none

        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        bus.OutReady = 1'b1;

        // Full dump, OutReady held high: latency and total length.
        load_pattern();
        x0 = xfers;
        issue_start();
        cyc = 1;
        chk("read_cycle_valid", 64'(bus.OutValid), 64'd0);
        chk("read_cycle_busy",  64'(bus.Busy),     64'd1);
        tick();
        cyc++;
        chk("first_valid", 64'(bus.OutValid), 64'd1);
        chk("first_idx",   64'(bus.OutIdx),   64'd0);
        wait_done(cyc);
        chk("dump_cycles", 64'(cyc), 64'(EXP_CYC));
        chk("dump_xfers",  64'(xfers - x0), 64'(NWORDS));
        tick();
        chk("done_width", 64'(bus.Done), 64'd0);
        chk("idle_busy",  64'(bus.Busy), 64'd0);

        // Stall on index 7 while RdData wanders.
        x0 = xfers;
        issue_start();
        wait_idx(7);
        bus.OutReady = 1'b0;
        junk_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            junk = $urandom;
            tick();
            chk("stall_data",  64'(bus.OutData),  64'h77777777);
            chk("stall_idx",   64'(bus.OutIdx),   64'd7);
            chk("stall_valid", 64'(bus.OutValid), 64'd1);
        end
        junk_en = 1'b0;
        bus.OutReady = 1'b1;
        cyc = 0;
        wait_done(cyc);
        chk("stall_xfers", 64'(xfers - x0), 64'(NWORDS));
        tick();

        // Single non-zero register: checksum equals that register.
        for (int i = 0; i < NREG; i++) regs[i] = {DW{1'b0}};
        regs[1] = 32'hA5A5A5A5;
        x0 = xfers;
        issue_start();
        cyc = 1;
        wait_done(cyc);
        chk("csum_xfers", 64'(xfers - x0), 64'(NWORDS));
        tick();

        // Abort during SEND of index 10 with a transfer pending.
        load_pattern();
        issue_start();
        wait_idx(10);
        bus.Abort = 1'b1;
        exp_q.delete();
        tick();
        bus.Abort = 1'b0;
        chk("abort_valid", 64'(bus.OutValid), 64'd0);
        chk("abort_busy",  64'(bus.Busy),     64'd0);
        chk("abort_done",  64'(bus.Done),     64'd0);
        tick();
        chk("abort_done_late", 64'(bus.Done), 64'd0);
        issue_start();
        tick();
        chk("restart_valid", 64'(bus.OutValid), 64'd1);
        chk("restart_idx",   64'(bus.OutIdx),   64'd0);
        cyc = 2;
        wait_done(cyc);
        tick();

        // Reset during READ of index 20, with Start and Abort also asserted.
        issue_start();
        cyc = 0;
        while (bus.RdAdr != 5'd20 && cyc < 300) begin
            tick();
            cyc++;
        end
        chk("reach_read20", 64'(bus.RdAdr), 64'd20);
        rst_n = 1'b0;
        bus.Start = 1'b1;
        bus.Abort = 1'b1;
        tick();
        check_reset_outputs("midreset");
        exp_q.delete();
        rst_n = 1'b1;
        bus.Start = 1'b0;
        bus.Abort = 1'b0;
        tick();
        chk("postreset_busy", 64'(bus.Busy), 64'd0);

        // Start while dumping and during DONE is ignored.
        x0 = xfers;
        issue_start();
        wait_idx(5);
        bus.Start = 1'b1;
        tick();
        tick();
        bus.Start = 1'b0;
        cyc = 0;
        wait_done(cyc);
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        chk("done_start_busy",  64'(bus.Busy),     64'd0);
        chk("done_start_valid", 64'(bus.OutValid), 64'd0);
        tick();
        chk("done_start_busy2", 64'(bus.Busy), 64'd0);
        chk("ignored_xfers", 64'(xfers - x0), 64'(NWORDS));

        // Random contents under random backpressure.
        rand_rdy = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NREG; i++) regs[i] = $urandom;
            x0 = xfers;
            issue_start();
            cyc = 1;
            wait_done(cyc);
            chk("rand_xfers", 64'(xfers - x0), 64'(NWORDS));
            tick();
        end
        rand_rdy = 1'b0;
        bus.OutReady = 1'b1;

        tick();
        tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
